mod_msg_schedule: RTL

- SHA-256 message-schedule stage, directly upstream of the compressor.
- Accepts one 512-bit padded block; streams W[0..63], one word per accepted cycle, with the round index T that drives the compressor's I/W_IN.
- Uses a 16-word sliding window, so no 64-word W memory is needed.
- Downstream backpressure through W_READY; block-level handshake on the input side.

---
 rtl/sha256_pkg.sv | 32 +++
 rtl/mod_schedule_sigma.sv | 19 +
 rtl/mod_msg_schedule.sv | 93 +++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/round constants, K table, initial hash, small sigmas
// and the schedule FSM state type.
package sha256_pkg;
    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} sched_state_t;

    localparam logic [31:0] SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] SHA_H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
endpackage

// File: rtl/mod_schedule_sigma.sv
// Next message-schedule word from the 16-word window:
// sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32.
module mod_schedule_sigma #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] w_next
);
    import sha256_pkg::*;

    logic [WORD_W-1:0] s0, s1;

    assign s0     = sigma0(w1);
    assign s1     = sigma1(w14);
    assign w_next = s1 + w9 + s0 + w0;
endmodule

// File: rtl/mod_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block, streams W[0..63] from a 16-word window.
// Optional MOD_MSG_SCHEDULE_K_ROM_EN adds K_OUT, the round constant aligned with W_OUT.
module mod_msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [16*WORD_W-1:0] BLOCK_IN,
    input  logic                BLOCK_VALID,
    output logic                BLOCK_READY,
    output logic [WORD_W-1:0]   W_OUT,
    output logic [5:0]          T_OUT,
    output logic                W_VALID,
    input  logic                W_READY,
    output logic                DONE
`ifdef MOD_MSG_SCHEDULE_K_ROM_EN
   ,output logic [WORD_W-1:0]   K_OUT
`endif
);
    import sha256_pkg::*;

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    sched_state_t state_q, state_d;
    logic [15:0][WORD_W-1:0] win;
    logic [5:0]              t_q;
    logic [WORD_W-1:0]       w_next;
    logic                    load, accept;

    assign load   = (state_q == IDLE) && BLOCK_VALID;
    assign accept = (state_q == STREAM) && W_READY;

    mod_schedule_sigma #(.WORD_W(WORD_W)) u_sigma (
        .w0    (win[0]),
        .w1    (win[1]),
        .w9    (win[9]),
        .w14   (win[14]),
        .w_next(w_next)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (BLOCK_VALID) state_d = STREAM;
            STREAM:  if (W_READY && t_q == T_LAST) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window shifts toward win[0]; the freshly expanded word enters at win[15].
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            win <= '0;
            t_q <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++)
                win[i] <= BLOCK_IN[(15-i)*WORD_W +: WORD_W];
            t_q <= '0;
        end else if (accept) begin
            win <= {w_next, win[15:1]};
            t_q <= t_q + 6'd1;
        end
    end

`ifdef MOD_MSG_SCHEDULE_K_ROM_EN
    logic [WORD_W-1:0] k_q;

    // Looked up one step ahead so K lands in the same cycle as its W.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)       k_q <= '0;
        else if (load)   k_q <= SHA_K[0];
        else if (accept) k_q <= SHA_K[t_q + 6'd1];
    end
`endif

    always_comb begin
        BLOCK_READY = (state_q == IDLE);
        W_VALID     = (state_q == STREAM);
        DONE        = (state_q == FINISH);
        W_OUT       = (state_q == STREAM) ? win[0] : '0;
        T_OUT       = t_q;
`ifdef MOD_MSG_SCHEDULE_K_ROM_EN
        K_OUT       = (state_q == STREAM) ? k_q : '0;
`endif
    end
endmodule
